// File: rtl/matmult_pkg.sv
// Shared definitions for the matrix-multiply job scheduler.
package matmult_pkg;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefNElem = 16;
  localparam int unsigned DefTmo   = 1024;
  localparam int unsigned IdxW     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLOgot,
    StLData,
    StLWait,
    StROgot,
    StRRead,
    StDone
  } sched_state_e;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: rise_o = in_i & ~in_i(previous cycle).
module edge_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic rise_o
);

  logic prev_q;

  // Remember the previous level of the input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= in_i;
  end

  assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/matmult_sched.sv
// Two-client job scheduler feeding a 4x4 matrix-multiply engine: loads A/B pairs,
// reads back results (first read of each job is a dummy), with a handshake watchdog.
module matmult_sched
  import matmult_pkg::*;
#(
  parameter int unsigned DW     = DefDw,
  parameter int unsigned N_ELEM = DefNElem,
  parameter int unsigned TMO    = DefTmo
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_i,
  output logic [1:0]      gnt_o,
  input  logic [DW-1:0]   in_a_i,
  input  logic [DW-1:0]   in_b_i,
  input  logic            in_valid_i,
  output logic            in_take_o,
  output logic [DW-1:0]   res_o,
  output logic [IdxW-1:0] res_idx_o,
  output logic            res_id_o,
  output logic            res_valid_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            err_o,
  output logic [DW-1:0]   mm_a_o,
  output logic [DW-1:0]   mm_b_o,
  input  logic [DW-1:0]   mm_r_i,
  output logic            mm_i_ready_o,
  output logic            mm_o_got_o,
  input  logic            mm_rdy_i,
  input  logic            mm_gotit_i,
  input  logic            mm_out_ready_i
);

  localparam int unsigned CntW = $clog2(N_ELEM + 1);
  localparam int unsigned WdW  = $clog2(TMO + 1);

  sched_state_e    state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d, err_q, err_d, dummy_q, dummy_d;
  logic            cli_q, cli_d, ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic [DW-1:0]   mm_a_q, mm_a_d, mm_b_q, mm_b_d, res_q, res_d;
  logic [IdxW-1:0] res_idx_q, res_idx_d;
  logic            res_id_q, res_id_d, res_valid_q, res_valid_d;
  logic            rdy_rise, gotit_rise, oready_rise;
  logic            wd_on, timeout, pick;

  edge_rise u_rdy_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (mm_rdy_i),
    .rise_o (rdy_rise)
  );

  edge_rise u_gotit_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (mm_gotit_i),
    .rise_o (gotit_rise)
  );

  edge_rise u_oready_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (mm_out_ready_i),
    .rise_o (oready_rise)
  );

  // Watchdog only guards engine handshakes; client stalls in StLData are unbounded.
  assign wd_on   = (state_q == StLOgot) || (state_q == StLWait) ||
                   (state_q == StROgot) || (state_q == StRRead);
  assign timeout = wd_on && (wdog_q == WdW'(TMO - 1));

  // Next-state logic for the job sequencer, arbitration and watchdog.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    dummy_d     = dummy_q;
    cli_d       = cli_q;
    ptr_d       = ptr_q;
    mm_a_d      = mm_a_q;
    mm_b_d      = mm_b_q;
    res_d       = res_q;
    res_idx_d   = res_idx_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;
    pick        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          pick    = (req_i == 2'b11) ? ptr_q : req_i[1];
          cli_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          dummy_d = 1'b0;
          state_d = StLOgot;
        end
      end
      StLOgot: if (rdy_rise) state_d = StLData;
      StLData: begin
        if (in_valid_i) begin
          mm_a_d  = in_a_i;
          mm_b_d  = in_b_i;
          state_d = StLWait;
        end
      end
      StLWait: begin
        if (gotit_rise) begin
          if (cnt_q == CntW'(N_ELEM - 1)) begin
            cnt_d   = '0;
            dummy_d = 1'b1;
            state_d = StROgot;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StLOgot;
          end
        end
      end
      StROgot: if (oready_rise) state_d = StRRead;
      StRRead: begin
        if (gotit_rise) begin
          if (dummy_q) begin
            // Engine's first read after loading carries no result.
            dummy_d = 1'b0;
            state_d = StROgot;
          end else begin
            res_d       = mm_r_i;
            res_idx_d   = IdxW'(cnt_q);
            res_id_d    = cli_q;
            res_valid_d = 1'b1;
            if (cnt_q == CntW'(N_ELEM - 1)) begin
              cnt_d   = '0;
              gnt_d   = 2'b00;
              busy_d  = 1'b0;
              state_d = StDone;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = StROgot;
            end
          end
        end
      end
      StDone: begin
        ptr_d   = ~cli_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      err_d       = 1'b1;
      gnt_d       = 2'b00;
      busy_d      = 1'b0;
      cnt_d       = '0;
      dummy_d     = 1'b0;
      res_valid_d = 1'b0;
      state_d     = StIdle;
    end
    wdog_d = (!wd_on || (state_d != state_q)) ? '0 : wdog_q + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      dummy_q     <= 1'b0;
      cli_q       <= 1'b0;
      ptr_q       <= 1'b0;
      wdog_q      <= '0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      res_q       <= '0;
      res_idx_q   <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      dummy_q     <= dummy_d;
      cli_q       <= cli_d;
      ptr_q       <= ptr_d;
      wdog_q      <= wdog_d;
      mm_a_q      <= mm_a_d;
      mm_b_q      <= mm_b_d;
      res_q       <= res_d;
      res_idx_q   <= res_idx_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Handshake drives decode straight from state, so they can never overlap.
  assign mm_o_got_o   = (state_q == StLOgot) || (state_q == StROgot);
  assign mm_i_ready_o = (state_q == StLWait) || (state_q == StRRead);
  assign in_take_o    = (state_q == StLData);
  assign done_o       = (state_q == StDone);
  assign gnt_o        = gnt_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign mm_a_o       = mm_a_q;
  assign mm_b_o       = mm_b_q;
  assign res_o        = res_q;
  assign res_idx_o    = res_idx_q;
  assign res_id_o     = res_id_q;
  assign res_valid_o  = res_valid_q;

endmodule

// File: tb/tb_matmult_sched.sv
// Directed bench for matmult_sched: behavioural engine and client, table-driven result checks.
module tb_matmult_sched;

  localparam int unsigned TMO = 1024;
  localparam logic [31:0] ONE = 32'h3F800000;

  typedef struct {
    logic [31:0] a0;   // client 0 A element (identity)
    logic [31:0] a1;   // client 1 A element (row-reversal)
    logic [31:0] b;    // B element, both clients
    logic [31:0] e0;   // expected result, client 0
    logic [31:0] e1;   // expected result, client 1
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] rowv[4];

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [1:0]  req = 2'b00, gnt;
  logic [31:0] in_a = '0, in_b = '0, res, mm_a, mm_b, mm_r = '0;
  logic        in_valid = 1'b0, in_take, res_id, res_valid, done, busy, err;
  logic [3:0]  res_idx;
  logic        mm_i_ready, mm_o_got, mm_rdy = 1'b0, mm_gotit = 1'b0, mm_out_ready = 1'b0;

  int n_chk = 0, n_pass = 0;
  int ovl = 0, done_cnt = 0, rd = 0, ld = 0, res_cnt = 0, elem = 0, stall_left = 0;
  int stall_cfg = 0;
  bit eng_en = 1'b1, xfer = 1'b0, busy_prev = 1'b0;
  logic [31:0] res_log[16], a_mem[16], b_mem[16];
  logic        res_id_log;

  matmult_sched #(.DW(32), .N_ELEM(16), .TMO(TMO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .gnt_o          (gnt),
    .in_a_i         (in_a),
    .in_b_i         (in_b),
    .in_valid_i     (in_valid),
    .in_take_o      (in_take),
    .res_o          (res),
    .res_idx_o      (res_idx),
    .res_id_o       (res_id),
    .res_valid_o    (res_valid),
    .done_o         (done),
    .busy_o         (busy),
    .err_o          (err),
    .mm_a_o         (mm_a),
    .mm_b_o         (mm_b),
    .mm_r_i         (mm_r),
    .mm_i_ready_o   (mm_i_ready),
    .mm_o_got_o     (mm_o_got),
    .mm_rdy_i       (mm_rdy),
    .mm_gotit_i     (mm_gotit),
    .mm_out_ready_i (mm_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Client driver, engine model and monitor, all stepped on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_valid = 1'b0; mm_rdy = 1'b0; mm_gotit = 1'b0; mm_out_ready = 1'b0;
        rd = 0; ld = 0; elem = 0; xfer = 1'b0; busy_prev = 1'b0; res_cnt = 0;
        continue;
      end
      if ((mm_o_got && mm_i_ready) || gnt == 2'b11) ovl++;
      if (busy && !busy_prev) begin
        res_cnt = 0; ld = 0; rd = 0; elem = 0; xfer = 1'b0; stall_left = stall_cfg;
      end
      busy_prev = busy;
      if (res_valid) begin
        res_log[res_idx] = res; res_id_log = res_id; res_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("read_edges", rd, 17);
      end
      // client
      if (xfer) elem++;
      if (elem == 5 && stall_left > 0) begin
        stall_left--;
        in_valid = 1'b0;
      end else begin
        in_valid = (gnt != 2'b00) && (elem < 16);
      end
      if (elem < 16) begin
        in_a = gnt[1] ? tbl[elem].a1 : tbl[elem].a0;
        in_b = tbl[elem].b;
      end
      xfer = in_valid && in_take;
      // engine
      mm_rdy = 1'b0; mm_gotit = 1'b0; mm_out_ready = 1'b0;
      if (eng_en) begin
        if (mm_o_got) begin
          if (ld < 16) mm_rdy = 1'b1;
          else         mm_out_ready = 1'b1;
        end else if (mm_i_ready) begin
          if (ld < 16) begin
            a_mem[ld] = mm_a; b_mem[ld] = mm_b; ld++;
          end else if (rd == 0) begin
            mm_r = 32'hDEADBEEF; rd++;
          end else begin
            mm_r = '0;
            for (int k = 0; k < 4; k++)
              if (a_mem[((rd - 1) / 4) * 4 + k] == ONE) mm_r = b_mem[k * 4 + (rd - 1) % 4];
            rd++;
          end
          mm_gotit = 1'b1;
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, {30'b0, gnt}, 32'h0);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_strobes"}, {29'b0, done, res_valid, in_take}, 32'h0);
    check({tag, "_hs"}, {30'b0, mm_o_got, mm_i_ready}, 32'h0);
    check({tag, "_data"}, mm_a | mm_b | res | {28'b0, res_idx}, 32'h0);
    check({tag, "_err"}, {31'b0, err}, 32'h0);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (busy) break;
    end
    check("grant_seen", {31'b0, busy}, 32'h1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check("job_done", {31'b0, done}, 32'h1);
    check("done_gnt_busy", {29'b0, gnt, busy}, 32'h0);
  endtask

  task automatic check_job(input logic cl);
    @(negedge clk); #1;
    check("res_count", res_cnt, 16);
    check("res_id", {31'b0, res_id_log}, {31'b0, cl});
    check("err_clear", {31'b0, err}, 32'h0);
    for (int e = 0; e < 16; e++)
      check($sformatf("res_%0d_c%0d", e, cl), res_log[e], cl ? tbl[e].e1 : tbl[e].e0);
  endtask

  int cyc;
  int done_before;

  initial begin
    rowv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    for (int e = 0; e < 16; e++) begin
      tbl[e].a0 = (e / 4 == e % 4) ? ONE : 32'h0;
      tbl[e].a1 = (e / 4 == 3 - e % 4) ? ONE : 32'h0;
      tbl[e].b  = rowv[e / 4];
      tbl[e].e0 = rowv[e / 4];
      tbl[e].e1 = rowv[3 - e / 4];
    end

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_quiet("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Identity load by client 0; req dropped mid-job
    @(negedge clk) req = 2'b01;
    wait_busy();
    check("gnt_c0", {30'b0, gnt}, 32'h1);
    req = 2'b00;
    wait_done();
    check_job(1'b0);
    check("first_idx0", res_log[0], 32'h3F800000);
    check("first_idx15", res_log[15], 32'h40800000);

    // Simultaneous requests after reset: client 0 then client 1
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) req = 2'b11;
    wait_busy();
    check("rr_first", {30'b0, gnt}, 32'h1);
    wait_done();
    check_job(1'b0);
    wait_busy();
    check("rr_second", {30'b0, gnt}, 32'h2);
    req = 2'b00;
    wait_done();
    check_job(1'b1);

    // Watchdog: engine never raises mm_rdy
    eng_en = 1'b0;
    done_before = done_cnt;
    @(negedge clk) req = 2'b01;
    wait_busy();
    req = 2'b00;
    cyc = 0;
    while (!err && cyc < TMO + 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("wd_cycles", cyc, TMO);
    check("wd_gnt", {30'b0, gnt}, 32'h0);
    check("wd_busy", {31'b0, busy}, 32'h0);
    repeat (5) @(posedge clk);
    #1 check("wd_sticky", {31'b0, err}, 32'h1);
    check("wd_no_done", done_cnt, done_before);
    eng_en = 1'b1;

    // Reset during the read of element 7, then a full job
    @(negedge clk) req = 2'b01;
    wait_busy();
    req = 2'b00;
    check("err_cleared", {31'b0, err}, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (mm_i_ready && rd == 8) break;
    end
    check("pre_reset_results", res_cnt, 7);
    rst_n = 1'b0;
    #1 check_quiet("midjob_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) req = 2'b01;
    wait_busy();
    req = 2'b00;
    wait_done();
    check_job(1'b0);

    // Long client stall in the load phase must not trip the watchdog
    stall_cfg = 3000;
    @(negedge clk) req = 2'b01;
    wait_busy();
    req = 2'b00;
    wait_done();
    check_job(1'b0);
    stall_cfg = 0;

    check("handshake_overlap", ovl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

endmodule
